// File: rtl/z80_bus_responder_if.sv
// Z80 CPU bus bundle: address, data both ways, strobes and the wait request.
// The CPU (or its model) is the master, and the memory/IO responder is the slave.
interface z80_bus_responder_if;
    logic [15:0] A;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic        wait_n;

    modport master (
        output A, di, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        input  dout, wait_n
    );

    modport slave (
        input  A, di, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        output dout, wait_n
    );
endinterface

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: mirrored byte memory, IO passthrough, interrupt-acknowledge vector,
// programmable wait states, and a host preload port that only works while the bus is idle.
module z80_bus_responder #(
    parameter int          AW       = 12,
    parameter int          WAIT_MEM = 0,
    parameter int          WAIT_IO  = 1,
    parameter logic [7:0]  INT_VEC  = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    z80_bus_responder_if.slave   bus,
    input  logic                 ld_en,
    input  logic [AW-1:0]        ld_addr,
    input  logic [7:0]           ld_data,
    output logic                 ld_drop,
    input  logic [7:0]           io_rdata,
    output logic [7:0]           io_port,
    output logic [7:0]           io_data,
    output logic                 io_we
);
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] T_MEMRD  = 3'd0;
    localparam logic [2:0] T_MEMWR  = 3'd1;
    localparam logic [2:0] T_IORD   = 3'd2;
    localparam logic [2:0] T_IOWR   = 3'd3;
    localparam logic [2:0] T_INTACK = 3'd4;

    localparam logic [3:0] WM = 4'(WAIT_MEM);
    localparam logic [3:0] WI = 4'(WAIT_IO);

    logic [7:0]    mem [0:DEPTH-1];

    logic [1:0]    state_q, state_d;
    logic [2:0]    kind_q, kind_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    port_q, port_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wait_n_q, wait_n_d;
    logic [7:0]    dout_q, dout_d;
    logic          io_we_q, io_we_d;
    logic [7:0]    io_port_q, io_port_d;
    logic [7:0]    io_data_q, io_data_d;
    logic          ld_drop_q, ld_drop_d;

    logic          cls_vld;
    logic [2:0]    cls_kind;
    logic [3:0]    cls_wait;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [7:0]    mem_wd;

    // Upper address bits only select a mirror of the array.
    logic unused_a;
    assign unused_a = ^bus.A[15:AW];

    // Priority order matters: refresh shares mreq_n with memory cycles and must win.
    always_comb begin
        cls_vld  = 1'b1;
        cls_kind = T_MEMRD;
        if (!bus.mreq_n && !bus.rfsh_n)     cls_vld  = 1'b0;
        else if (!bus.m1_n && !bus.iorq_n)  cls_kind = T_INTACK;
        else if (!bus.mreq_n && !bus.rd_n)  cls_kind = T_MEMRD;
        else if (!bus.mreq_n && !bus.wr_n)  cls_kind = T_MEMWR;
        else if (!bus.iorq_n && !bus.rd_n)  cls_kind = T_IORD;
        else if (!bus.iorq_n && !bus.wr_n)  cls_kind = T_IOWR;
        else                                cls_vld  = 1'b0;
        cls_wait = (cls_kind == T_MEMRD || cls_kind == T_MEMWR) ? WM : WI;
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        addr_d    = addr_q;
        port_d    = port_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        io_we_d   = 1'b0;
        io_port_d = io_port_q;
        io_data_d = io_data_q;
        mem_we    = 1'b0;
        mem_wa    = ld_addr;
        mem_wd    = ld_data;

        case (state_q)
            S_IDLE: begin
                if (cls_vld) begin
                    kind_d  = cls_kind;
                    addr_d  = bus.A[AW-1:0];
                    port_d  = bus.A[7:0];
                    data_d  = bus.di;
                    cnt_d   = cls_wait;
                    state_d = (cls_wait != 4'd0) ? S_WAIT : S_ACCESS;
                end else if (ld_en) begin
                    mem_we = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                case (kind_q)
                    T_MEMRD:  dout_d = mem[addr_q];
                    T_MEMWR: begin
                        mem_we = 1'b1;
                        mem_wa = addr_q;
                        mem_wd = data_q;
                    end
                    T_IORD: begin
                        dout_d    = io_rdata;
                        io_port_d = port_q;
                    end
                    T_IOWR: begin
                        io_we_d   = 1'b1;
                        io_port_d = port_q;
                        io_data_d = data_q;
                    end
                    T_INTACK: dout_d = INT_VEC;
                    default:  ;
                endcase
                state_d = S_DONE;
            end
            default: begin
                if (bus.mreq_n && bus.iorq_n) state_d = S_IDLE;
            end
        endcase

        ld_drop_d = ld_en && !(state_q == S_IDLE && !cls_vld);
        wait_n_d  = (state_d != S_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            kind_q    <= T_MEMRD;
            addr_q    <= '0;
            port_q    <= 8'h00;
            data_q    <= 8'h00;
            cnt_q     <= 4'd0;
            wait_n_q  <= 1'b1;
            dout_q    <= 8'h00;
            io_we_q   <= 1'b0;
            io_port_q <= 8'h00;
            io_data_q <= 8'h00;
            ld_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            addr_q    <= addr_d;
            port_q    <= port_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            wait_n_q  <= wait_n_d;
            dout_q    <= dout_d;
            io_we_q   <= io_we_d;
            io_port_q <= io_port_d;
            io_data_q <= io_data_d;
            ld_drop_q <= ld_drop_d;
        end
    end

    // Memory contents survive reset; there is deliberately no reset on this array.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus.dout   = dout_q;
    assign bus.wait_n = wait_n_q;
    assign io_we      = io_we_q;
    assign io_port    = io_port_q;
    assign io_data    = io_data_q;
    assign ld_drop    = ld_drop_q;
endmodule
